// File: rtl/audio_ctrl_pkg.sv
// Shared types and default thresholds for the audio-driven movement controller.
package audio_ctrl_pkg;

  typedef enum logic [1:0] {
    CLS_NONE = 2'd0,
    CLS_WALK = 2'd1,
    CLS_JUMP = 2'd2
  } frame_class_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    POP  = 2'd2
  } ctrl_state_e;

  localparam logic [23:0] DEF_WALK_TH = 24'h01FFFF;
  localparam logic [23:0] DEF_JUMP_TH = 24'h0FFFFF;

endpackage

// File: rtl/audio_frame_controller_if.sv
// Codec FIFO read handshake: the controller (master) pops samples from the codec (slave).
interface audio_frame_controller_if #(
  parameter int DATA_W = 24
);
  logic [DATA_W-1:0] left;
  logic              read_ready;
  logic              read;

  modport master (input left, input read_ready, output read);
  modport slave  (output left, output read_ready, input read);
endinterface

// File: rtl/audio_frame_controller_abs_sat.sv
// Saturating absolute value of a two's complement sample.
module abs_sat #(
  parameter int DATA_W = 24
) (
  input  logic [DATA_W-1:0] x,
  output logic [DATA_W-1:0] y
);

  localparam logic [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] MOST_POS = {1'b0, {(DATA_W-1){1'b1}}};

  always_comb begin
    y = x;
    // The most-negative code has no positive twin, so clamp it.
    if (x == MOST_NEG) begin
      y = MOST_POS;
    end else if (x[DATA_W-1]) begin
      y = -x;
    end
  end

endmodule

// File: rtl/audio_frame_controller.sv
// Pops codec samples, tracks per-frame left-channel peak and turns it into
// debounced walk/jump levels at each 60 Hz frame boundary.
module audio_frame_controller
  import audio_ctrl_pkg::*;
#(
  parameter int                DATA_W      = 24,
  parameter logic [DATA_W-1:0] WALK_TH     = DATA_W'(DEF_WALK_TH),
  parameter logic [DATA_W-1:0] JUMP_TH     = DATA_W'(DEF_JUMP_TH),
  parameter int                HOLD_FRAMES = 2,
  parameter int                CNT_W       = 16
) (
  input  logic                     clk_50,
  input  logic                     resetn,
  input  logic                     enable,
  input  logic                     clk_60hz,
  audio_frame_controller_if.master codec,
  output logic                     walk,
  output logic                     jump,
  output logic [DATA_W-1:0]        peak,
  output logic [CNT_W-1:0]         sample_count,
  output logic                     frame_done
);

  localparam logic [3:0] HOLD_4 = 4'(HOLD_FRAMES);

  logic [2:0]        tick_sync_reg;
  logic              frame_edge;
  ctrl_state_e       state_reg;
  logic              read_reg;
  logic [DATA_W-1:0] sample_reg;
  logic [DATA_W-1:0] sample_abs;
  logic [DATA_W-1:0] acc_reg;
  logic [CNT_W-1:0]  cnt_reg;
  frame_class_e      last_class_reg;
  frame_class_e      frame_class;
  logic [3:0]        run_reg;
  logic [3:0]        run_next;
  logic              walk_reg;
  logic              jump_reg;
  logic [DATA_W-1:0] peak_reg;
  logic [CNT_W-1:0]  sample_count_reg;
  logic              frame_done_reg;

  // Stages 0/1 synchronise the tick; stage 2 holds the previous value for edge detect.
  always_ff @(posedge clk_50 or negedge resetn) begin
    if (!resetn) begin
      tick_sync_reg <= '0;
    end else begin
      tick_sync_reg <= {tick_sync_reg[1:0], clk_60hz};
    end
  end

  assign frame_edge = tick_sync_reg[1] & ~tick_sync_reg[2];

  abs_sat #(.DATA_W(DATA_W)) u_abs_sat (
    .x (sample_reg),
    .y (sample_abs)
  );

  always_comb begin
    frame_class = CLS_NONE;
    if (acc_reg >= JUMP_TH) begin
      frame_class = CLS_JUMP;
    end else if (acc_reg >= WALK_TH) begin
      frame_class = CLS_WALK;
    end

    run_next = 4'd1;
    if (frame_class == last_class_reg) begin
      run_next = (run_reg >= HOLD_4) ? HOLD_4 : run_reg + 4'd1;
    end
  end

  always_ff @(posedge clk_50 or negedge resetn) begin
    if (!resetn) begin
      state_reg        <= IDLE;
      read_reg         <= 1'b0;
      sample_reg       <= '0;
      acc_reg          <= '0;
      cnt_reg          <= '0;
      last_class_reg   <= CLS_NONE;
      run_reg          <= '0;
      walk_reg         <= 1'b0;
      jump_reg         <= 1'b0;
      peak_reg         <= '0;
      sample_count_reg <= '0;
      frame_done_reg   <= 1'b0;
    end else begin
      frame_done_reg <= 1'b0;
      if (!enable) begin
        state_reg      <= IDLE;
        read_reg       <= 1'b0;
        acc_reg        <= '0;
        cnt_reg        <= '0;
        last_class_reg <= CLS_NONE;
        run_reg        <= '0;
        walk_reg       <= 1'b0;
        jump_reg       <= 1'b0;
      end else begin
        case (state_reg)
          IDLE: state_reg <= WAIT;
          WAIT: begin
            if (codec.read_ready) begin
              sample_reg <= codec.left;
              read_reg   <= 1'b1;
              state_reg  <= POP;
            end
          end
          POP: begin
            read_reg  <= 1'b0;
            state_reg <= WAIT;
          end
          default: begin
            read_reg  <= 1'b0;
            state_reg <= IDLE;
          end
        endcase

        if (state_reg != IDLE && frame_edge) begin
          peak_reg         <= acc_reg;
          sample_count_reg <= cnt_reg;
          frame_done_reg   <= 1'b1;
          last_class_reg   <= frame_class;
          run_reg          <= run_next;
          if (run_next == HOLD_4) begin
            walk_reg <= (frame_class != CLS_NONE);
            jump_reg <= (frame_class == CLS_JUMP);
          end
          // A sample popped on the edge cycle belongs to the frame just starting.
          if (state_reg == POP) begin
            acc_reg <= sample_abs;
            cnt_reg <= CNT_W'(1);
          end else begin
            acc_reg <= '0;
            cnt_reg <= '0;
          end
        end else if (state_reg == POP) begin
          if (sample_abs > acc_reg) begin
            acc_reg <= sample_abs;
          end
          if (cnt_reg != '1) begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
      end
    end
  end

  assign codec.read   = read_reg;
  assign walk         = walk_reg;
  assign jump         = jump_reg;
  assign peak         = peak_reg;
  assign sample_count = sample_count_reg;
  assign frame_done   = frame_done_reg;

endmodule

// File: tb/tb_audio_frame_controller.sv
// Randomised scoreboard bench for audio_frame_controller with a frame-level reference model.
module tb_audio_frame_controller;

  localparam int DATA_W  = 24;
  localparam int CNT_W   = 16;
  localparam int HOLD    = 2;
  localparam int WALK_TH = 24'h01FFFF;
  localparam int JUMP_TH = 24'h0FFFFF;

  logic              clk_50   = 1'b0;
  logic              resetn   = 1'b0;
  logic              enable   = 1'b0;
  logic              clk_60hz = 1'b0;
  logic              walk;
  logic              jump;
  logic [DATA_W-1:0] peak;
  logic [CNT_W-1:0]  sample_count;
  logic              frame_done;

  audio_frame_controller_if #(.DATA_W(DATA_W)) cif ();

  audio_frame_controller #(
    .DATA_W      (DATA_W),
    .WALK_TH     (24'h01FFFF),
    .JUMP_TH     (24'h0FFFFF),
    .HOLD_FRAMES (HOLD),
    .CNT_W       (CNT_W)
  ) dut (
    .clk_50       (clk_50),
    .resetn       (resetn),
    .enable       (enable),
    .clk_60hz     (clk_60hz),
    .codec        (cif),
    .walk         (walk),
    .jump         (jump),
    .peak         (peak),
    .sample_count (sample_count),
    .frame_done   (frame_done)
  );

  always #10 clk_50 = ~clk_50;

  typedef struct {
    int peak;
    int cnt;
    bit walk;
    bit jump;
  } exp_t;

  int          n_vec = 0;
  int          n_err = 0;
  int          fd_count = 0;
  int          n_expected = 0;
  bit          rand_gap = 1'b1;
  logic [23:0] codec_q[$];
  exp_t        sb_q[$];
  int          cur_frame[$];
  int          cls_hist[$];
  bit          m_walk = 1'b0;
  bit          m_jump = 1'b0;

  task automatic check(input string name, input longint act, input longint exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int mag_of(input logic [23:0] s);
    int v;
    v = int'($signed(s));
    if (v < 0) v = -v;
    if (v > 24'h7FFFFF) v = 24'h7FFFFF;
    return v;
  endfunction

  function automatic int class_of(input int m);
    if (m >= JUMP_TH) return 2;
    if (m >= WALK_TH) return 1;
    return 0;
  endfunction

  task automatic model_clear();
    cur_frame.delete();
    cls_hist.delete();
    m_walk = 1'b0;
    m_jump = 1'b0;
  endtask

  // Close the current frame in the model and queue the expected report.
  task automatic model_edge();
    exp_t e;
    int   pk;
    int   c;
    bit   same;
    pk = 0;
    foreach (cur_frame[i]) if (cur_frame[i] > pk) pk = cur_frame[i];
    c = class_of(pk);
    cls_hist.push_back(c);
    if (cls_hist.size() >= HOLD) begin
      same = 1'b1;
      for (int i = 1; i <= HOLD; i++) if (cls_hist[cls_hist.size() - i] != c) same = 1'b0;
      if (same) begin
        m_walk = (c != 0);
        m_jump = (c == 2);
      end
    end
    e.peak = pk;
    e.cnt  = (cur_frame.size() > 16'hFFFF) ? 16'hFFFF : cur_frame.size();
    e.walk = m_walk;
    e.jump = m_jump;
    sb_q.push_back(e);
    n_expected++;
    cur_frame.delete();
  endtask

  task automatic push_sample(input logic [23:0] s);
    codec_q.push_back(s);
    cur_frame.push_back(mag_of(s));
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (codec_q.size() > 0 && t < 300) begin
      @(negedge clk_50);
      t++;
    end
    check("drain", codec_q.size(), 0);
    repeat (2) @(negedge clk_50);
  endtask

  task automatic frame_edge_tick();
    @(negedge clk_50);
    clk_60hz = 1'b1;
    repeat (6) @(negedge clk_50);
    clk_60hz = 1'b0;
    repeat (3) @(negedge clk_50);
  endtask

  task automatic end_frame();
    wait_drain();
    model_edge();
    frame_edge_tick();
  endtask

  // Frame whose peak magnitude is exactly target, with a random sign on each sample.
  task automatic peak_frame(input int target);
    int          n;
    int          at;
    logic [23:0] s;
    n  = $urandom_range(1, 5);
    at = $urandom_range(0, n - 1);
    for (int i = 0; i < n; i++) begin
      s = (i == at) ? target[23:0] : 24'($urandom_range(0, target - 1));
      if ($urandom_range(0, 1) == 1) s = -s;
      push_sample(s);
    end
    end_frame();
  endtask

  function automatic logic [23:0] rand_sample();
    logic [23:0] s;
    case ($urandom_range(0, 6))
      0:       s = 24'(WALK_TH - 1);
      1:       s = 24'(WALK_TH);
      2:       s = 24'(JUMP_TH - 1);
      3:       s = 24'(JUMP_TH);
      4:       return 24'h800000;
      5:       return 24'($urandom);
      default: s = 24'($urandom_range(0, 255));
    endcase
    if ($urandom_range(0, 1) == 1) s = -s;
    return s;
  endfunction

  // Codec FIFO model: presents the head sample, pops it when read is seen.
  initial begin
    logic rd;
    cif.read_ready = 1'b0;
    cif.left       = '0;
    forever begin
      @(negedge clk_50);
      rd = cif.read;
      @(posedge clk_50);
      if (rd && codec_q.size() > 0) void'(codec_q.pop_front());
      #1;
      if (codec_q.size() > 0 && (!rand_gap || $urandom_range(0, 3) != 0)) begin
        cif.read_ready = 1'b1;
        cif.left       = codec_q[0];
      end else begin
        cif.read_ready = 1'b0;
        cif.left       = 24'($urandom);
      end
    end
  end

  // Monitor: pops an expectation for every frame_done pulse.
  initial begin
    logic prev_read;
    exp_t e;
    prev_read = 1'b0;
    forever begin
      @(negedge clk_50);
      if (resetn) begin
        if (cif.read) check("read_back_to_back", prev_read, 0);
        if (frame_done) begin
          fd_count++;
          if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("peak", peak, e.peak);
            check("sample_count", sample_count, e.cnt);
            check("walk", walk, e.walk);
            check("jump", jump, e.jump);
            $display("frame %0d: peak=%06h count=%0d walk=%0b jump=%0b", fd_count, peak,
                     sample_count, walk, jump);
          end
        end
      end
      prev_read = cif.read;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int t;
    int rd_cnt;
    int fd_before;

    @(negedge clk_50);
    check("reset_read", cif.read, 0);
    check("reset_walk", walk, 0);
    check("reset_jump", jump, 0);
    check("reset_peak", peak, 0);
    check("reset_count", sample_count, 0);
    check("reset_frame_done", frame_done, 0);
    resetn = 1'b1;
    repeat (2) @(negedge clk_50);
    enable = 1'b1;
    repeat (3) @(negedge clk_50);

    // Continuous read_ready: one pop every two cycles.
    rand_gap = 1'b0;
    for (int i = 0; i < 10; i++) push_sample(24'($urandom_range(0, 24'h00FFFF)));
    t = 0;
    while (!cif.read_ready && t < 50) begin
      @(negedge clk_50);
      t++;
    end
    check("read_ready_seen", cif.read_ready, 1);
    rd_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (cif.read) rd_cnt++;
      @(negedge clk_50);
    end
    check("read_pulses_20cyc", rd_cnt, 10);
    end_frame();
    rand_gap = 1'b1;

    // Peak with saturation of the most-negative code.
    push_sample(24'h000100);
    push_sample(24'hF00000);
    push_sample(24'h800000);
    push_sample(24'h020000);
    end_frame();

    // Threshold boundaries and debounce.
    peak_frame(WALK_TH);
    peak_frame(WALK_TH);
    peak_frame(JUMP_TH);
    peak_frame(JUMP_TH);
    peak_frame(WALK_TH - 1);

    for (int f = 0; f < 14; f++) begin
      n = $urandom_range(0, 6);
      for (int i = 0; i < n; i++) push_sample(rand_sample());
      end_frame();
    end

    // Pop landing on the synchronised frame edge starts the next frame.
    rand_gap = 1'b0;
    push_sample(24'h001234);
    push_sample(24'hFFE000);
    wait_drain();
    @(negedge clk_50);
    clk_60hz = 1'b1;
    model_edge();
    push_sample(24'h050000);
    repeat (6) @(negedge clk_50);
    clk_60hz = 1'b0;
    repeat (3) @(negedge clk_50);
    push_sample(24'h000777);
    push_sample(24'hFFF000);
    end_frame();
    rand_gap = 1'b1;

    // Enable drop with walk asserted; edges while idle must be ignored.
    peak_frame(WALK_TH + 5);
    peak_frame(WALK_TH);
    check("walk_before_drop", walk, m_walk);
    @(negedge clk_50);
    enable = 1'b0;
    model_clear();
    @(posedge clk_50);
    #1;
    check("drop_read", cif.read, 0);
    check("drop_walk", walk, m_walk);
    check("drop_jump", jump, m_jump);
    fd_before = fd_count;
    frame_edge_tick();
    frame_edge_tick();
    check("frame_done_while_idle", fd_count - fd_before, 0);
    enable = 1'b1;
    repeat (2) @(negedge clk_50);

    // Asynchronous reset in the middle of a frame.
    peak_frame(JUMP_TH + 100);
    peak_frame(JUMP_TH);
    for (int i = 0; i < 5; i++) push_sample(rand_sample());
    wait_drain();
    #3;
    resetn = 1'b0;
    #1;
    check("async_reset_read", cif.read, 0);
    check("async_reset_walk", walk, 0);
    check("async_reset_jump", jump, 0);
    check("async_reset_peak", peak, 0);
    check("async_reset_count", sample_count, 0);
    model_clear();
    enable = 1'b0;
    repeat (2) @(negedge clk_50);
    resetn = 1'b1;
    for (int i = 0; i < 3; i++) push_sample(rand_sample());
    rd_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_50);
      if (cif.read) rd_cnt++;
    end
    check("idle_no_reads", rd_cnt, 0);
    check("idle_queue_kept", codec_q.size(), 3);
    enable = 1'b1;
    end_frame();

    repeat (10) @(negedge clk_50);
    check("frame_done_total", fd_count, n_expected);
    check("scoreboard_empty", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
